// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - scan inputs and display outputs of the seven-segment scan driver
interface ssd_scan_driver_if;
    logic        scan_clk;
    logic [15:0] digit_val;
    logic [3:0]  digit_en;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic [1:0]  scan_idx;

    modport master (
        output scan_clk, digit_val, digit_en, dp_in,
        input  an, seg, dp_n, scan_idx
    );

    modport slave (
        input  scan_clk, digit_val, digit_en, dp_in,
        output an, seg, dp_n, scan_idx
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - four-digit multiplexed seven-segment driver with anode blanking guard
// Optional leading-zero suppression: define SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
    parameter int BLANK_CYCLES = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    ssd_scan_driver_if.slave disp
);
    logic             s1, s2, s3;
    logic             scan_edge;
    logic [CNT_W-1:0] blank_cnt;
    logic             active;
    logic [1:0]       idx_q;
    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_q;
    logic [3:0]       nibble;
    logic [6:0]       seg_dec;
    logic [3:0]       en_eff;
    logic [3:0]       anode_next;

    // scan_clk is a strobe from another divider; only its synchronised rising edge matters
    assign scan_edge = s2 & ~s3;

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [3:0] suppress;
    always_comb begin
        suppress    = 4'b0000;
        suppress[3] = (disp.digit_val[15:12] == 4'h0) && !disp.dp_in[3];
        suppress[2] = suppress[3] && (disp.digit_val[11:8] == 4'h0) && !disp.dp_in[2];
        suppress[1] = suppress[2] && (disp.digit_val[7:4] == 4'h0) && !disp.dp_in[1];
    end
    assign en_eff = disp.digit_en & ~suppress;
`else
    assign en_eff = disp.digit_en;
`endif

    always_comb begin
        nibble = disp.digit_val[3:0];
        case (idx_q)
            2'd0: nibble = disp.digit_val[3:0];
            2'd1: nibble = disp.digit_val[7:4];
            2'd2: nibble = disp.digit_val[11:8];
            2'd3: nibble = disp.digit_val[15:12];
            default: nibble = disp.digit_val[3:0];
        endcase
    end

    always_comb begin
        seg_dec = 7'h7F;
        case (nibble)
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase
    end

    always_comb begin
        anode_next        = 4'hF;
        anode_next[idx_q] = ~en_eff[idx_q];
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            idx_q     <= 2'd3;
            blank_cnt <= '0;
            active    <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            s1 <= disp.scan_clk;
            s2 <= s1;
            s3 <= s2;
            // A new edge always wins, discarding any blanking still in progress
            if (scan_edge) begin
                idx_q     <= idx_q + 2'd1;
                blank_cnt <= CNT_W'(BLANK_CYCLES);
                an_q      <= 4'hF;
                active    <= 1'b1;
            end else if (blank_cnt != '0) begin
                blank_cnt <= blank_cnt - CNT_W'(1);
                an_q      <= 4'hF;
            end else if (active) begin
                an_q <= anode_next;
            end
            // Segments are not blanked, but stay dark until the first scan edge
            if (active) begin
                seg_q <= seg_dec;
                dp_q  <= ~disp.dp_in[idx_q];
            end
        end
    end

    assign disp.an       = an_q;
    assign disp.seg      = seg_q;
    assign disp.dp_n     = dp_q;
    assign disp.scan_idx = idx_q;
endmodule
